// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the button debouncer.
// State encoding is fixed so level is the MSB of the state.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO = 2'b00,
    WT_HI = 2'b01,
    ST_HI = 2'b11,
    WT_LO = 2'b10
  } state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  function automatic logic is_high(state_e st);
    return (st == ST_HI) || (st == WT_LO);
  endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// N-stage single-bit synchroniser.
// All stages clear to 0 on synchronous reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw pin through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser plus counter-qualified FSM.
// Emits a registered level and one-cycle rise/fall pulses.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               SINGLE  = (DEBOUNCE_CYCLES == 1);

  logic             s;
  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             rise_n;
  logic             fall_n;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (s)
  );

  assign cnt_inc = cnt + CNT_ONE;

  // Next state, counter and pulse decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      ST_LO: begin
        if (s) begin
          if (SINGLE) begin
            state_n = ST_HI;
            cnt_n   = '0;
            rise_n  = 1'b1;
          end else begin
            state_n = WT_HI;
            cnt_n   = CNT_ONE;
          end
        end
      end
      WT_HI: begin
        if (!s) begin
          state_n = ST_LO;
          cnt_n   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_n = ST_HI;
          cnt_n   = '0;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (SINGLE) begin
            state_n = ST_LO;
            cnt_n   = '0;
            fall_n  = 1'b1;
          end else begin
            state_n = WT_LO;
            cnt_n   = CNT_ONE;
          end
        end
      end
      WT_LO: begin
        if (s) begin
          state_n = ST_HI;
          cnt_n   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_n = ST_LO;
          cnt_n   = '0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = ST_LO;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LO;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      level      <= is_high(state_n);
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Pulse edge numbers are queued at stimulus time and matched on output.
module tb_btn_debounce;

  localparam int S   = 2;
  localparam int N   = 4;
  localparam int LAT = S + N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b1;
  logic level;
  logic rise_pulse;
  logic fall_pulse;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rise_q[$];
  int fall_q[$];

  btn_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: match each pulse against the queued edge number
  always @(negedge clk) begin
    if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL both_pulses cyc=%0d rise=1 fall=1 required not both", cyc);
    end
    if (rise_pulse === 1'b1) begin
      checks++;
      if (rise_q.size() == 0) begin
        errors++;
        $display("FAIL rise_unexpected cyc=%0d got pulse, required none", cyc);
      end else begin
        if (rise_q[0] !== cyc) begin
          errors++;
          $display("FAIL rise_edge got cyc=%0d required cyc=%0d", cyc, rise_q[0]);
        end
        void'(rise_q.pop_front());
      end
    end else if (rise_q.size() != 0 && rise_q[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rise_missed at cyc=%0d rise=%b required 1", rise_q[0], rise_pulse);
      void'(rise_q.pop_front());
    end
    if (fall_pulse === 1'b1) begin
      checks++;
      if (fall_q.size() == 0) begin
        errors++;
        $display("FAIL fall_unexpected cyc=%0d got pulse, required none", cyc);
      end else begin
        if (fall_q[0] !== cyc) begin
          errors++;
          $display("FAIL fall_edge got cyc=%0d required cyc=%0d", cyc, fall_q[0]);
        end
        void'(fall_q.pop_front());
      end
    end else if (fall_q.size() != 0 && fall_q[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL fall_missed at cyc=%0d fall=%b required 1", fall_q[0], fall_pulse);
      void'(fall_q.pop_front());
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rise_q.size() == 0 && fall_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL reset_level got %b required 0", level);
    end
    checks++;
    if (rise_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_rise got %b required 0", rise_pulse);
    end
    checks++;
    if (fall_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_fall got %b required 0", fall_pulse);
    end
    rst = 1'b0;
    rise_q.push_back(cyc + LAT);
    wait_drain(30);
    checks++;
    if (rise_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release_timeout pending=%0d required 0", rise_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_level got %b required 1", level);
    end
  endtask

  task automatic test_release;
    btn_in = 1'b0;
    fall_q.push_back(cyc + LAT);
    wait_drain(30);
    checks++;
    if (fall_q.size() != 0) begin
      errors++;
      $display("FAIL release_timeout pending=%0d required 0", fall_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL release_level got %b required 0", level);
    end
  endtask

  task automatic test_clean_press;
    @(negedge clk);
    btn_in = 1'b1;
    rise_q.push_back(cyc + LAT);
    wait_drain(30);
    checks++;
    if (rise_q.size() != 0) begin
      errors++;
      $display("FAIL press_timeout pending=%0d required 0", rise_q.size());
    end
    repeat (10) @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL press_level got %b required 1", level);
    end
  endtask

  task automatic test_bounce_reject;
    logic [3:0] pat;
    pat = 4'b0111;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      btn_in = pat[i % 4];
      checks++;
      if (level !== 1'b0) begin
        errors++;
        $display("FAIL bounce_level i=%0d got %b required 0", i, level);
      end
    end
    @(negedge clk);
    btn_in = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_end_level got %b required 0", level);
    end
  endtask

  task automatic test_bounce_settle;
    logic [3:0] pat;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_in = pat[i];
    end
    @(negedge clk);
    btn_in = 1'b1;
    rise_q.push_back(cyc + LAT);
    wait_drain(30);
    checks++;
    if (rise_q.size() != 0) begin
      errors++;
      $display("FAIL settle_timeout pending=%0d required 0", rise_q.size());
    end
    repeat (4) @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL settle_level got %b required 1", level);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL midwait_level got %b required 0", level);
    end
    checks++;
    if (rise_pulse !== 1'b0) begin
      errors++;
      $display("FAIL midwait_rise got %b required 0", rise_pulse);
    end
    rst = 1'b0;
    rise_q.push_back(cyc + LAT);
    wait_drain(30);
    checks++;
    if (rise_q.size() != 0) begin
      errors++;
      $display("FAIL midwait_timeout pending=%0d required 0", rise_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL midwait_final_level got %b required 1", level);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    btn_in = 1'b1;
    rise_q.push_back(cyc + LAT);
    repeat (LAT) @(negedge clk);
    checks++;
    if (level !== 1'b1) begin
      errors++;
      $display("FAIL b2b_level_hi got %b required 1", level);
    end
    btn_in = 1'b0;
    fall_q.push_back(cyc + LAT);
    wait_drain(30);
    checks++;
    if (rise_q.size() != 0 || fall_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout pending=%0d required 0", rise_q.size() + fall_q.size());
    end
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL b2b_level_lo got %b required 0", level);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_clean_press();
    test_release();
    test_bounce_reject();
    test_bounce_settle();
    test_release();
    test_reset_mid_wait();
    test_release();
    test_back_to_back();
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
